cp0: RTL and testbench

Coprocessor-0 state holder and exception sequencer for the five-stage MIPS pipeline. It owns SR, Cause, EPC and PRId. It commits exception entry and `eret` exit, and services `mtc0`/`mfc0` from the M stage. It feeds `ie`, `im` and `exl` back to the M-stage exception detector, which asserts `EXLSet` for one cycle when an exception or interrupt is taken.

---
 rtl/cp0_pkg.sv | 27 ++
 rtl/cp0.sv | 122 ++++++++++++
 tb/tb_cp0.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field positions, exception codes.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 10;
  localparam int CA_IP_HI  = 15;
  localparam int CA_BD     = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] PRID_DEFAULT = 32'h4252_2017;

endpackage

// File: rtl/cp0.sv
// CP0 state holder and exception sequencer (SR, Cause, EPC, PRId).
// Define CP0_BD_EN to rewind EPC onto the branch for delay-slot victims.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = PRID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  input  logic        EXLSet,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPC,
  output logic        ie,
  output logic        exl,
  output logic [5:0]  im
);

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [5:0]  im_q, im_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;

  logic        entry;
  logic        wr_sr;
  logic        wr_epc;
  logic [31:0] pc_al;
  logic [31:0] sr_w;
  logic [31:0] cause_w;

  assign entry  = EXLSet & ~exl_q;
  assign wr_sr  = We & (A2 == CP0_SR);
  assign wr_epc = We & (A2 == CP0_EPC);
  assign pc_al  = {PC[31:2], 2'b00};

  always_comb begin
    ie_d  = ie_q;
    exl_d = exl_q;
    im_d  = im_q;
    ip_d  = HWInt;
    exc_d = exc_q;
    bd_d  = bd_q;
    epc_d = epc_q;
    if (wr_sr) begin
      im_d  = DIn[SR_IM_HI:SR_IM_LO];
      ie_d  = DIn[SR_IE];
      exl_d = DIn[SR_EXL];
    end
    if (wr_epc) epc_d = {DIn[31:2], 2'b00};
    if (EXLClr) exl_d = 1'b0;
    if (entry) begin
      exl_d = 1'b1;
      exc_d = ExcCode;
`ifdef CP0_BD_EN
      bd_d  = BD;
      epc_d = BD ? pc_al - 32'd4 : pc_al;
`else
      bd_d  = 1'b0;
      epc_d = pc_al;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      im_q  <= '0;
      ip_q  <= '0;
      exc_q <= '0;
      bd_q  <= 1'b0;
      epc_q <= '0;
    end else begin
      ie_q  <= ie_d;
      exl_q <= exl_d;
      im_q  <= im_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      bd_q  <= bd_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    sr_w = '0;
    sr_w[SR_IM_HI:SR_IM_LO] = im_q;
    sr_w[SR_EXL] = exl_q;
    sr_w[SR_IE]  = ie_q;
    cause_w = '0;
    cause_w[CA_BD] = bd_q;
    cause_w[CA_IP_HI:CA_IP_LO] = ip_q;
    cause_w[CA_EXC_HI:CA_EXC_LO] = exc_q;
  end

  // Read mux sees pre-edge state only; no mtc0 bypass.
  always_comb begin
    case (A1)
      CP0_SR:    DOut = sr_w;
      CP0_CAUSE: DOut = cause_w;
      CP0_EPC:   DOut = epc_q;
      CP0_PRID:  DOut = PRID_VAL;
      default:   DOut = '0;
    endcase
  end

  assign EPC = epc_q;
  assign ie  = ie_q;
  assign exl = exl_q;
  assign im  = im_q;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: word-level reference model plus directed checks.
module tb_cp0;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCode;
  logic [31:0] DIn, PC;
  logic        We, BD, EXLSet, EXLClr;
  logic [5:0]  HWInt;
  logic [31:0] DOut, EPC;
  logic        ie, exl;
  logic [5:0]  im;

  int n_chk = 0;
  int n_fail = 0;
  bit en = 1'b0;

  logic [31:0] m_sr = 0, m_cause = 0, m_epc = 0;

`ifdef CP0_BD_EN
  localparam bit BDEN = 1'b1;
`else
  localparam bit BDEN = 1'b0;
`endif

  cp0 dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .We(We),
    .PC(PC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt),
    .EXLSet(EXLSet), .EXLClr(EXLClr), .DOut(DOut), .EPC(EPC),
    .ie(ie), .exl(exl), .im(im)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h4252_2017;
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: whole-register arithmetic from the rules.
  always @(posedge clk) begin
    logic [31:0] nsr, ncause, nepc;
    logic take;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      take = EXLSet && (m_sr[1] == 1'b0);
      nsr = m_sr;
      nepc = m_epc;
      ncause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
      if (We && A2 == 5'd12) nsr = DIn & 32'h0000_FC03;
      if (We && A2 == 5'd14) nepc = DIn & ~32'h3;
      if (EXLClr) nsr = nsr & ~32'h2;
      if (take) begin
        nsr = nsr | 32'h2;
        nepc = (PC & ~32'h3) - ((BDEN && BD) ? 32'd4 : 32'd0);
        ncause = (ncause & 32'h0000_FC00) | (32'(ExcCode) << 2)
               | ((BDEN && BD) ? 32'h8000_0000 : 32'h0);
      end
      m_sr = nsr; m_cause = ncause; m_epc = nepc;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("dout", DOut, m_read(A1));
      chk("epc", EPC, m_epc);
      chk("sr_flags", {24'h0, im, exl, ie},
          {24'h0, m_sr[15:10], m_sr[1], m_sr[0]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    We = 0; EXLSet = 0; EXLClr = 0; BD = 0; HWInt = 0;
  endtask

  initial begin
    reset = 1; A1 = 0; A2 = 0; DIn = 0; PC = 0; ExcCode = 0;
    idle();
    step(); step();
    reset = 0;
    en = 1;
    // reset state
    A1 = 12; #1 chk("rst_sr", DOut, 32'h0);
    A1 = 13; #1 chk("rst_cause", DOut, 32'h0);
    A1 = 14; #1 chk("rst_epc", DOut, 32'h0);
    A1 = 15; #1 chk("rst_prid", DOut, 32'h4252_2017);
    chk("rst_flags", {im, exl, ie}, 8'h0);
    // mtc0 SR with same-cycle mfc0
    We = 1; A2 = 12; DIn = 32'h0000_0C01; A1 = 12;
    #1 chk("mtc0_nobypass", DOut, 32'h0);
    step(); We = 0;
    chk("mtc0_sr_ie", ie, 1'b1);
    chk("mtc0_sr_im", im, 6'b000011);
    chk("mtc0_sr_exl", exl, 1'b0);
    // exception entry
    EXLSet = 1; PC = 32'h0000_3010; ExcCode = 5; BD = 0;
    step(); EXLSet = 0; A1 = 13;
    #1 chk("entry_exl", exl, 1'b1);
    chk("entry_epc", EPC, 32'h0000_3010);
    chk("entry_cause", DOut, 32'h0000_0014);
    EXLSet = 1; PC = 32'h0000_4000; ExcCode = 12;
    step(); EXLSet = 0;
    chk("nested_epc", EPC, 32'h0000_3010);
    EXLClr = 1; step(); EXLClr = 0;
    chk("eret_exl", exl, 1'b0);
    // delay-slot victim
    EXLSet = 1; BD = 1; PC = 32'h0000_3020; ExcCode = 4;
    step(); idle(); A1 = 13;
    #1 chk("bd_epc", EPC, BDEN ? 32'h0000_301C : 32'h0000_3020);
    chk("bd_cause31", DOut[31], BDEN);
    EXLClr = 1; step(); EXLClr = 0;
    // entry vs mtc0 EPC
    EXLSet = 1; PC = 32'h0000_3040; ExcCode = 0;
    We = 1; A2 = 14; DIn = 32'h0000_5000;
    step(); idle();
    chk("prio_epc", EPC, 32'h0000_3040);
    EXLClr = 1; step(); EXLClr = 0;
    chk("prio_eret_exl", exl, 1'b0);
    chk("prio_eret_epc", EPC, 32'h0000_3040);
    // IP sampling
    HWInt = 6'b000010; step(); HWInt = 0; A1 = 13;
    #1 chk("ip_set", DOut[15:10], 6'b000010);
    step(); chk("ip_clr", DOut[15:10], 6'b0);
    HWInt = 6'b000010; EXLSet = 1; PC = 32'h0000_3100;
    step(); idle();
    chk("ip_entry", DOut[15:10], 6'b000010);
    EXLClr = 1; step(); EXLClr = 0;
    // randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      A1      = 5'($urandom_range(10, 17));
      A2      = 5'($urandom_range(10, 17));
      DIn     = $urandom;
      We      = ($urandom_range(0, 9) < 3);
      PC      = $urandom;
      BD      = 1'($urandom);
      ExcCode = 5'($urandom);
      HWInt   = 6'($urandom);
      EXLSet  = ($urandom_range(0, 9) < 2);
      EXLClr  = ($urandom_range(0, 9) < 2);
      step();
    end
    reset = 0; idle();
    step();
    en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
